// File: rtl/shift_sequencer_pkg.sv
// Purpose: shared state encoding and default widths for the shift sequencer slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_sequencer_pkg;

    localparam int REG_WIDTH   = 8;
    localparam int SHIFT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/shift_count_down.sv
// Purpose: loadable CNT_W-bit down-counter tracking remaining shift cycles.
// Latency: load/decrement visible one cycle after the enabling edge.
// Backpressure: none; it counts whenever enabled and saturates at zero.
// Ports: clk, reset (sync, active-high), load + load_value (load wins over enable),
//        enable (decrement), count (current value), is_one (count == 1).
module shift_count_down
    import shift_sequencer_pkg::*;
#(
    parameter int CNT_W = SHIFT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             is_one
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // Decoded from the register so the FSM can leave SHIFT on the last shift cycle.
    assign is_one = (count == CNT_W'(1));

endmodule

// File: rtl/shift_sequencer.sv
// Purpose: command-driven controller for an 8-bit load/shift-right register (one load, N shifts, done pulse).
// Latency: accept at edge k -> load_n low cycle k+1, shift k+2..k+1+N, done k+2+N, ready again k+3+N.
// Backpressure: cmd_ready is high only in IDLE; cmd_valid is ignored (not queued) while busy.
// Ports: clk, reset (sync, active-high); cmd_valid/cmd_ready/cmd_value/cmd_count/cmd_arith command
//        handshake; abort cancel; load_n/shift/asr/load_val register controls; busy, done, shifts_left status.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH,
    parameter int CNT_W = SHIFT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_value,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_arith,
    input  logic             abort,
    output logic             load_n,
    output logic             shift,
    output logic             asr,
    output logic [WIDTH-1:0] load_val,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] shifts_left
);

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_is_one;

    // cmd_ready is decoded from state only. An abort in IDLE still blocks the
    // accept below, so upstream must keep cmd_valid up until a real accept.
    assign cmd_ready = (state_q == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready && !abort;

    // The counter is zero in IDLE, so loading zero on any abort covers the
    // mid-transaction cancel without a separate clear input.
    assign cnt_load  = accept || abort;
    assign cnt_value = abort ? '0 : cmd_count;

    shift_count_down #(
        .CNT_W (CNT_W)
    ) u_count (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (cnt_value),
        .enable     (state_q == ST_SHIFT),
        .count      (shifts_left),
        .is_one     (cnt_is_one)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            load_val <= '0;
            asr      <= 1'b0;
        end else begin
            state_q <= state_d;
            // Latched operands persist through the return to IDLE.
            if (accept) begin
                load_val <= cmd_value;
                asr      <= cmd_arith;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_LOAD;
            ST_LOAD:  state_d = (shifts_left != '0) ? ST_SHIFT : ST_DONE;
            ST_SHIFT: if (cnt_is_one) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    assign load_n = (state_q != ST_LOAD);
    assign shift  = (state_q == ST_SHIFT);
    assign done   = (state_q == ST_DONE);
    assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Purpose: directed self-checking bench for shift_sequencer with a behavioural downstream register.
// Latency: checks every cycle of each transaction against hand-derived timing.
// Backpressure: exercises held cmd_valid, abort in IDLE and mid-shift, and reset mid-shift.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_value;
    logic [3:0] cmd_count;
    logic       cmd_arith;
    logic       abort;
    logic       load_n;
    logic       shift;
    logic       asr;
    logic [7:0] load_val;
    logic       busy;
    logic       done;
    logic [3:0] shifts_left;

    logic [7:0] q;
    int         shift_cnt;
    int         done_cnt;
    int         n_vec;
    int         n_err;

    always #5 clk = ~clk;

    shift_sequencer #(
        .WIDTH (8),
        .CNT_W (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_value   (cmd_value),
        .cmd_count   (cmd_count),
        .cmd_arith   (cmd_arith),
        .abort       (abort),
        .load_n      (load_n),
        .shift       (shift),
        .asr         (asr),
        .load_val    (load_val),
        .busy        (busy),
        .done        (done),
        .shifts_left (shifts_left)
    );

    // Downstream load/shift-right register plus pulse counters.
    always @(posedge clk) begin
        if (!load_n)    q <= load_val;
        else if (shift) q <= asr ? {q[7], q[7:1]} : {1'b0, q[7:1]};
        if (shift) shift_cnt <= shift_cnt + 1;
        if (done)  done_cnt  <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, cmd_ready, 1);
        chk({tag, "_load_n"}, load_n, 1);
        chk({tag, "_shift"}, shift, 0);
        chk({tag, "_asr"}, asr, 0);
        chk({tag, "_load_val"}, load_val, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_left"}, shifts_left, 0);
    endtask

    // One full transaction with per-cycle timing checks; exp_q is the register result.
    task automatic run_cmd(input logic [7:0] v, input logic [3:0] n, input logic a,
                           input logic [7:0] exp_q);
        @(negedge clk);
        chk("pre_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_value = v; cmd_count = n; cmd_arith = a;
        shift_cnt = 0; done_cnt = 0;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_value = 8'hEE; cmd_count = 4'd9; cmd_arith = ~a;
        chk("load_n_low", load_n, 0);
        chk("load_shift", shift, 0);
        chk("load_ready", cmd_ready, 0);
        chk("load_busy", busy, 1);
        chk("load_left", shifts_left, n);
        chk("load_val", load_val, v);
        chk("load_asr", asr, a);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("sh_shift", shift, 1);
            chk("sh_load_n", load_n, 1);
            chk("sh_done", done, 0);
            chk("sh_left", shifts_left, n - i);
        end
        @(negedge clk);
        chk("dn_done", done, 1);
        chk("dn_shift", shift, 0);
        chk("dn_load_n", load_n, 1);
        chk("dn_left", shifts_left, 0);
        chk("dn_ready", cmd_ready, 0);
        chk("dn_val", load_val, v);
        chk("dn_asr", asr, a);
        @(negedge clk);
        chk("end_ready", cmd_ready, 1);
        chk("end_done", done, 0);
        chk("end_busy", busy, 0);
        chk("end_val", load_val, v);
        chk("end_asr", asr, a);
        chk("end_nshift", shift_cnt, n);
        chk("end_ndone", done_cnt, 1);
        chk("end_q", q, exp_q);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0;
        shift_cnt = 0; done_cnt = 0;
        reset = 1'b1; abort = 1'b0;
        cmd_valid = 1'b0; cmd_value = 8'h00; cmd_count = 4'd0; cmd_arith = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_reset_vals("idle");
        end

        // Logical 3-shift: A5 >> 3 = 14.
        run_cmd(8'hA5, 4'd3, 1'b0, 8'h14);
        // Arithmetic 2-shift: 90 -> C8 -> E4.
        run_cmd(8'h90, 4'd2, 1'b1, 8'hE4);
        // Zero shifts: load only, done two cycles after accept.
        run_cmd(8'h3C, 4'd0, 1'b0, 8'h3C);

        // Max count, abort in the 4th shift cycle.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_value = 8'h81; cmd_count = 4'd15; cmd_arith = 1'b0;
        shift_cnt = 0; done_cnt = 0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("ab_load_n", load_n, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ab_shift", shift, 1);
            chk("ab_left", shifts_left, 15 - i);
            if (i == 3) abort = 1'b1;
        end
        @(negedge clk);
        abort = 1'b0;
        chk("ab_after_shift", shift, 0);
        chk("ab_after_load_n", load_n, 1);
        chk("ab_after_busy", busy, 0);
        chk("ab_after_ready", cmd_ready, 1);
        chk("ab_after_left", shifts_left, 0);
        chk("ab_after_done", done, 0);
        repeat (3) @(negedge clk);
        chk("ab_ndone", done_cnt, 0);
        chk("ab_nshift", shift_cnt, 4);
        chk("ab_val_held", load_val, 8'h81);

        // Abort in IDLE blocks acceptance.
        @(negedge clk);
        abort = 1'b1; cmd_valid = 1'b1; cmd_value = 8'h55; cmd_count = 4'd2; cmd_arith = 1'b1;
        @(negedge clk);
        abort = 1'b0; cmd_valid = 1'b0;
        chk("ai_busy", busy, 0);
        chk("ai_load_n", load_n, 1);
        chk("ai_val", load_val, 8'h81);
        chk("ai_asr", asr, 0);

        // cmd_valid held high across two commands.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_value = 8'h11; cmd_count = 4'd1; cmd_arith = 1'b0;
        shift_cnt = 0; done_cnt = 0;
        @(negedge clk);
        cmd_value = 8'h22; cmd_count = 4'd2; cmd_arith = 1'b1;
        chk("bb_load_n", load_n, 0);
        chk("bb_val_a", load_val, 8'h11);
        @(negedge clk);
        chk("bb_shift", shift, 1);
        chk("bb_ready_busy", cmd_ready, 0);
        chk("bb_val_hold", load_val, 8'h11);
        chk("bb_asr_hold", asr, 0);
        @(negedge clk);
        chk("bb_done", done, 1);
        chk("bb_ready_done", cmd_ready, 0);
        @(negedge clk);
        chk("bb_ready_again", cmd_ready, 1);
        chk("bb_not_busy", busy, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bb2_load_n", load_n, 0);
        chk("bb2_val", load_val, 8'h22);
        chk("bb2_asr", asr, 1);
        chk("bb2_left", shifts_left, 2);
        repeat (2) begin
            @(negedge clk);
            chk("bb2_shift", shift, 1);
        end
        @(negedge clk);
        chk("bb2_done", done, 1);
        @(negedge clk);
        chk("bb_ndone", done_cnt, 2);
        chk("bb_nshift", shift_cnt, 3);
        chk("bb_q", q, 8'h08);

        // Reset (together with abort) in the middle of SHIFT.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_value = 8'hC3; cmd_count = 4'd5; cmd_arith = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rs_shift", shift, 1);
        end
        reset = 1'b1; abort = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_mid");
        reset = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
